// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered WIDTH-bit ALU with valid/ready handshakes on both
// sides, status flags and an optional shift-add unsigned multiplier.
//
// Build option:
//   ALU_MUL_EN  defined   -> op 8 is an unsigned multiply (WIDTH+1 edges,
//                            BUSY state, result_hi datapath present)
//               undefined -> op 8 is illegal, BUSY removed, result_hi = 0
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   operand handshake (accept = in_valid & in_ready)
//   op, a, b, c_in      opcode, operands, carry in (ADD/SUB/SUB_A only)
//   out_valid/out_ready result handshake
//   result, result_hi   result (MUL: low half) and MUL high half (else 0)
//   c_out, zero, neg,   status flags, registered alongside the result
//   ovf, err
//   dbg_state           current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its data and valid until that edge; the
// outputs of this block are held stable while out_valid & !out_ready.
// in_ready depends combinationally on out_ready so that, in DONE, the old
// result can retire and a new operation be captured on the same edge.
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             c_out,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err,
   output logic [1:0]       dbg_state
);

   // ------------------------------------------------------------------
   // Opcodes
   // ------------------------------------------------------------------
   localparam logic [3:0] OP_AND    = 4'd0;
   localparam logic [3:0] OP_OR     = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_XNOR   = 4'd3;
   localparam logic [3:0] OP_NAND   = 4'd4;
   localparam logic [3:0] OP_ADD    = 4'd5;
   localparam logic [3:0] OP_SUB    = 4'd6;
   localparam logic [3:0] OP_SUB_A  = 4'd7;
   localparam logic [3:0] OP_PASS_A = 4'd9;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL    = 4'd8;
   localparam int         CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`endif

   // ------------------------------------------------------------------
   // FSM state encoding (BUSY only exists with the multiplier)
   // ------------------------------------------------------------------
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd2
   } state_t;
`endif

   state_t            state_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  result_q;
   logic              c_out_q;
   logic              zero_q;
   logic              neg_q;
   logic              ovf_q;
   logic              err_q;

   logic              accept;

   // Single-cycle datapath (evaluated on the live inputs; captured on accept)
   logic [WIDTH-1:0]  add_x;
   logic [WIDTH-1:0]  add_y;
   logic [WIDTH:0]    add_sum;
   logic              add_ovf;
   logic [WIDTH-1:0]  res_d;
   logic              c_d;
   logic              ovf_d;
   logic              err_d;
   logic              zero_d;
   logic              neg_d;

`ifdef ALU_MUL_EN
   // Multiplier: prod_q holds {partial high, remaining multiplier bits}.
   // Each BUSY cycle conditionally adds the multiplicand into the high half
   // and shifts the whole product right by one.
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   result_hi_q;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_d;
   logic               mul_last;
`endif

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Adder shared by ADD / SUB / SUB_A. Subtraction is done as x + ~y + c_in
   // so the caller controls the borrow through c_in.
   // ------------------------------------------------------------------
   always_comb begin
      add_x = a;
      add_y = b;
      case (op)
         OP_SUB: begin
            add_y = ~b;
         end
         OP_SUB_A: begin
            add_x = b;
            add_y = ~a;
         end
         default: begin
         end
      endcase
      add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, c_in};
      // Overflow: both addends share a sign that the sum does not.
      add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                (add_sum[WIDTH-1] != add_x[WIDTH-1]);
   end

   // ------------------------------------------------------------------
   // Result and flag selection for single-cycle operations
   // ------------------------------------------------------------------
   always_comb begin
      res_d = '0;
      c_d   = 1'b0;
      ovf_d = 1'b0;
      err_d = 1'b0;
      case (op)
         OP_AND:    res_d = a & b;
         OP_OR:     res_d = a | b;
         OP_XOR:    res_d = a ^ b;
         OP_XNOR:   res_d = ~(a ^ b);
         OP_NAND:   res_d = ~(a & b);
         OP_ADD,
         OP_SUB,
         OP_SUB_A: begin
            res_d = add_sum[WIDTH-1:0];
            c_d   = add_sum[WIDTH];
            ovf_d = add_ovf;
         end
         OP_PASS_A: res_d = a;
         // Illegal opcodes (and op 8 without the multiplier) report err with
         // a zero result. With the multiplier, op 8 never takes this path's
         // values because the FSM routes it to BUSY instead.
         default:   err_d = 1'b1;
      endcase
      zero_d = (res_d == '0);
      neg_d  = res_d[WIDTH-1];
   end

`ifdef ALU_MUL_EN
   // ------------------------------------------------------------------
   // One shift-add step
   // ------------------------------------------------------------------
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                 (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      prod_d   = {mul_sum, prod_q[WIDTH-1:1]};
      mul_last = (cnt_q == CW'(WIDTH - 1));
   end
`endif

   // ------------------------------------------------------------------
   // FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         c_out_q     <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
`ifdef ALU_MUL_EN
         result_hi_q <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
`ifdef ALU_MUL_EN
                  if (op == OP_MUL) begin
                     state_q     <= S_BUSY;
                     out_valid_q <= 1'b0;
                     mcand_q     <= a;
                     prod_q      <= {{WIDTH{1'b0}}, b};
                     cnt_q       <= '0;
                  end else begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= res_d;
                     result_hi_q <= '0;
                     c_out_q     <= c_d;
                     zero_q      <= zero_d;
                     neg_q       <= neg_d;
                     ovf_q       <= ovf_d;
                     err_q       <= err_d;
                  end
`else
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= res_d;
                  c_out_q     <= c_d;
                  zero_q      <= zero_d;
                  neg_q       <= neg_d;
                  ovf_q       <= ovf_d;
                  err_q       <= err_d;
`endif
               end else if ((state_q == S_DONE) && out_ready) begin
                  // Result retired with nothing new behind it.
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + CW'(1);
               if (mul_last) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= prod_d[WIDTH-1:0];
                  result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                  c_out_q     <= 1'b0;
                  zero_q      <= (prod_d == '0);
                  neg_q       <= prod_d[2*WIDTH-1];
                  ovf_q       <= (prod_d[2*WIDTH-1:WIDTH] != '0);
                  err_q       <= 1'b0;
               end
            end
`endif
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign out_valid = out_valid_q;
   assign result    = result_q;
`ifdef ALU_MUL_EN
   assign result_hi = result_hi_q;
`else
   assign result_hi = '0;
`endif
   assign c_out     = c_out_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign ovf       = ovf_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed testbench for alu_seq (WIDTH=8).
// Expected responses are pushed into exp_q when an operation is accepted;
// a monitor pops and compares whenever a result retires. Timing properties
// (latency, in_ready, stall stability, reset abort) are checked inline.
// Expected vector layout: {result_hi, result, c_out, zero, neg, ovf, err}.
// ---------------------------------------------------------------------------
module tb_alu_seq;
   localparam int W  = 8;
   localparam int EW = 2*W + 5;

   localparam logic [3:0] OP_AND    = 4'd0;
   localparam logic [3:0] OP_OR     = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_XNOR   = 4'd3;
   localparam logic [3:0] OP_NAND   = 4'd4;
   localparam logic [3:0] OP_ADD    = 4'd5;
   localparam logic [3:0] OP_SUB    = 4'd6;
   localparam logic [3:0] OP_SUB_A  = 4'd7;
   localparam logic [3:0] OP_MUL    = 4'd8;
   localparam logic [3:0] OP_PASS_A = 4'd9;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [3:0]    op        = 4'd0;
   logic [W-1:0]  a         = '0;
   logic [W-1:0]  b         = '0;
   logic          c_in      = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic [W-1:0]  result_hi;
   logic          c_out, zero, neg, ovf, err;
   logic [1:0]    dbg_state;

   int            checks = 0;
   int            errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_exp;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .c_out     (c_out),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [EW-1:0] mk(input logic [W-1:0] hi, input logic [W-1:0] res,
                                        input logic c, input logic z, input logic n,
                                        input logic o, input logic e);
      return {hi, res, c, z, n, o, e};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------- driver ----------------
   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic push, input logic [EW-1:0] e,
                        output int waited);
      op       = o;
      a        = x;
      b        = y;
      c_in     = ci;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: in_ready low for %0d cycles, expected accept", waited);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end else begin
         if (push) exp_q.push_back(e);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h, expected no result",
                     {result_hi, result, c_out, zero, neg, ovf, err});
         end else begin
            mon_exp = exp_q.pop_front();
            check("result_flags", 32'({result_hi, result, c_out, zero, neg, ovf, err}),
                  32'(mon_exp));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int w0, w1, w2, n, bad, seen;

      // reset
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'({out_valid, result_hi, result, c_out, zero, neg, ovf, err}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // back-to-back ADD, XOR, AND with out_ready=1
      issue(OP_ADD, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h18, 1, 0, 0, 1, 0), w0);
      issue(OP_XOR, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h17, 0, 0, 0, 0, 0), w1);
      issue(OP_AND, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h80, 0, 0, 1, 0, 0), w2);
      check("b2b_no_stall", 32'(w0 + w1 + w2), 32'd0);
      @(negedge clk);
      check("single_cycle_latency", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

      // subtractions
      issue(OP_SUB,   8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h09, 1, 0, 0, 0, 0), w0);
      issue(OP_SUB_A, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'hF7, 0, 0, 1, 0, 0), w0);

      // remaining logical ops, wrap-around, zero and signed overflow
      issue(OP_OR,   8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h97, 0, 0, 1, 0, 0), w0);
      issue(OP_XNOR, 8'h90, 8'h87, 1'b0, 1'b1, mk(8'h00, 8'hE8, 0, 0, 1, 0, 0), w0);
      issue(OP_NAND, 8'h90, 8'h87, 1'b0, 1'b1, mk(8'h00, 8'h7F, 0, 0, 0, 0, 0), w0);
      issue(OP_ADD,  8'hFF, 8'h01, 1'b0, 1'b1, mk(8'h00, 8'h00, 1, 1, 0, 0, 0), w0);
      issue(OP_ADD,  8'h7F, 8'h01, 1'b0, 1'b1, mk(8'h00, 8'h80, 0, 0, 1, 1, 0), w0);
      issue(OP_XOR,  8'h5A, 8'h5A, 1'b1, 1'b1, mk(8'h00, 8'h00, 0, 1, 0, 0, 0), w0);

      // multiply
`ifdef ALU_MUL_EN
      issue(OP_MUL, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h4B, 8'hF0, 0, 0, 0, 1, 0), w0);
      n   = 0;
      bad = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         if (in_ready) bad++;
         n++;
         @(negedge clk);
      end
      check("mul_latency", 32'(n), 32'd8);
      check("mul_in_ready_low", 32'(bad), 32'd0);
`else
      issue(OP_MUL, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h00, 0, 1, 0, 0, 1), w0);
      @(negedge clk);
      check("op8_illegal_latency", 32'(out_valid), 32'd1);
`endif
      @(posedge clk);
      #1;

      // illegal op, then a legal op clears err
      issue(4'hF,      8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h00, 0, 1, 0, 0, 1), w0);
      issue(OP_PASS_A, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h90, 0, 0, 1, 0, 0), w0);
      repeat (2) @(posedge clk);
      #1;

      // backpressure: result held for 3 cycles, then retired
      out_ready = 1'b0;
      issue(OP_ADD, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h18, 1, 0, 0, 1, 0), w0);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || result !== 8'h18 || c_out !== 1'b1 ||
             ovf !== 1'b1 || neg !== 1'b0 || err !== 1'b0) bad++;
      end
      check("stall_hold", 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_retired", 32'(out_valid), 32'd0);

      // reset 3 cycles into a multiply aborts it
      out_ready = 1'b0;
      issue(OP_MUL, 8'h90, 8'h87, 1'b1, 1'b0, '0, w0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_outputs", 32'({out_valid, result_hi, result, c_out, zero, neg, ovf, err}), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      seen      = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);
      @(posedge clk);
      #1;
      issue(OP_AND, 8'h90, 8'h87, 1'b1, 1'b1, mk(8'h00, 8'h80, 0, 0, 1, 0, 0), w0);

      // drain the scoreboard
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
